// File: rtl/conv_mac_ctrl.sv
// rtl/conv_mac_ctrl.sv - convolution MAC sequencer driving a shared 8x8 multiplier
// Optional busy-cycle counter port: CONV_MAC_CTRL_CYCLE_CNT_EN
module conv_mac_ctrl #(
    parameter int ADDR_W = 5,
    parameter int ACC_W  = 21
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W:0]   size_x_i,
    input  logic [ADDR_W:0]   size_y_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] x_addr_o,
    input  logic [7:0]        x_data_i,
    output logic [ADDR_W-1:0] y_addr_o,
    input  logic [7:0]        y_data_i,
    output logic [7:0]        mul_a_o,
    output logic [7:0]        mul_b_o,
    input  logic [15:0]       mul_p_i,
    output logic              z_we_o,
    output logic [ADDR_W:0]   z_addr_o,
    output logic [ACC_W-1:0]  z_data_o
`ifdef CONV_MAC_CTRL_CYCLE_CNT_EN
    ,
    output logic [15:0]       cycles_o
`endif
);

    typedef enum logic [2:0] {IDLE, SETUP, READ, MAC, WRITE, FIN} state_t;

    localparam logic [ADDR_W:0] ONE = 1;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     sx_q, sy_q, i_q;
    logic [ADDR_W-1:0]   k_q, kmax_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ADDR_W-1:0]   x_addr_q, y_addr_q;
    logic [ADDR_W:0]     z_addr_q;
    logic [ACC_W-1:0]    z_data_q;

    logic [ADDR_W:0]     sx_m1, sy_m1, i_last, k_min, k_max, y_idx;

    // Window of valid X indices for output i; sizes are nonzero whenever these are used.
    assign sx_m1  = sx_q - ONE;
    assign sy_m1  = sy_q - ONE;
    assign i_last = sx_m1 + sy_m1;
    assign k_min  = (i_q >= sy_m1) ? (i_q - sy_m1) : '0;
    assign k_max  = (i_q < sx_m1) ? i_q : sx_m1;
    assign y_idx  = i_q - {1'b0, k_q};

    always_comb begin
        state_d  = state_q;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        z_we_o   = 1'b0;
        mul_a_o  = '0;
        mul_b_o  = '0;
        x_addr_o = x_addr_q;
        y_addr_o = y_addr_q;
        z_addr_o = z_addr_q;
        z_data_o = z_data_q;
        case (state_q)
            IDLE: begin
                if (start_i)
                    state_d = (size_x_i == '0 || size_y_i == '0) ? FIN : SETUP;
            end
            SETUP: begin
                busy_o  = 1'b1;
                state_d = READ;
            end
            READ: begin
                busy_o   = 1'b1;
                x_addr_o = k_q;
                y_addr_o = y_idx[ADDR_W-1:0];
                state_d  = MAC;
            end
            MAC: begin
                busy_o  = 1'b1;
                mul_a_o = x_data_i;
                mul_b_o = y_data_i;
                state_d = (k_q == kmax_q) ? WRITE : READ;
            end
            WRITE: begin
                busy_o   = 1'b1;
                z_we_o   = 1'b1;
                z_addr_o = i_q;
                z_data_o = acc_q;
                state_d  = (i_q == i_last) ? FIN : SETUP;
            end
            FIN: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sx_q     <= '0;
            sy_q     <= '0;
            i_q      <= '0;
            k_q      <= '0;
            kmax_q   <= '0;
            acc_q    <= '0;
            x_addr_q <= '0;
            y_addr_q <= '0;
            z_addr_q <= '0;
            z_data_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        sx_q <= size_x_i;
                        sy_q <= size_y_i;
                        i_q  <= '0;
                    end
                end
                SETUP: begin
                    acc_q  <= '0;
                    k_q    <= k_min[ADDR_W-1:0];
                    kmax_q <= k_max[ADDR_W-1:0];
                end
                READ: begin
                    x_addr_q <= k_q;
                    y_addr_q <= y_idx[ADDR_W-1:0];
                end
                MAC: begin
                    acc_q <= acc_q + {{(ACC_W-16){1'b0}}, mul_p_i};
                    if (k_q != kmax_q)
                        k_q <= k_q + 1'b1;
                end
                WRITE: begin
                    z_addr_q <= i_q;
                    z_data_q <= acc_q;
                    if (i_q != i_last)
                        i_q <= i_q + ONE;
                end
                default: ;
            endcase
        end
    end

`ifdef CONV_MAC_CTRL_CYCLE_CNT_EN
    logic [15:0] cycles_q;

    always_ff @(posedge clk) begin
        if (rst)
            cycles_q <= '0;
        else if (state_q == IDLE && start_i)
            cycles_q <= '0;
        else if (busy_o)
            cycles_q <= cycles_q + 16'd1;
    end

    assign cycles_o = cycles_q;
`endif

endmodule

// File: tb/tb_conv_mac_ctrl.sv
// tb/tb_conv_mac_ctrl.sv - self-checking bench for conv_mac_ctrl against a convolution model
module tb_conv_mac_ctrl;

    localparam int ADDR_W = 5;
    localparam int ACC_W  = 21;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   size_x, size_y;
    logic              busy, done;
    logic [ADDR_W-1:0] x_addr, y_addr;
    logic [7:0]        x_data, y_data;
    logic [7:0]        mul_a, mul_b;
    logic [15:0]       mul_p;
    logic              z_we;
    logic [ADDR_W:0]   z_addr;
    logic [ACC_W-1:0]  z_data;
`ifdef CONV_MAC_CTRL_CYCLE_CNT_EN
    logic [15:0]       cycles;
`endif

    conv_mac_ctrl #(.ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .size_x_i (size_x),
        .size_y_i (size_y),
        .busy_o   (busy),
        .done_o   (done),
        .x_addr_o (x_addr),
        .x_data_i (x_data),
        .y_addr_o (y_addr),
        .y_data_i (y_data),
        .mul_a_o  (mul_a),
        .mul_b_o  (mul_b),
        .mul_p_i  (mul_p),
        .z_we_o   (z_we),
        .z_addr_o (z_addr),
        .z_data_o (z_data)
`ifdef CONV_MAC_CTRL_CYCLE_CNT_EN
        ,
        .cycles_o (cycles)
`endif
    );

    logic [7:0] xmem [32];
    logic [7:0] ymem [32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        x_data <= xmem[x_addr];
        y_data <= ymem[y_addr];
    end

    assign mul_p = {8'd0, mul_a} * {8'd0, mul_b};

    int  total = 0;
    int  bad = 0;
    int  exp_z [64];
    int  n_exp, exp_busy;
    int  wr_cnt, busy_cnt, done_cnt;
    int  zcap [64];
    logic prev_we;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Direct convolution sum plus per-output cycle cost 2+2*terms.
    task automatic model(input int sx, input int sy);
        n_exp = (sx == 0 || sy == 0) ? 0 : sx + sy - 1;
        exp_busy = 0;
        for (int i = 0; i < n_exp; i++) begin
            int s, t;
            s = 0;
            t = 0;
            for (int k = 0; k < sx; k++) begin
                if (i - k >= 0 && i - k < sy) begin
                    s += int'(xmem[k]) * int'(ymem[i - k]);
                    t++;
                end
            end
            exp_z[i] = s;
            exp_busy += 2 + 2 * t;
        end
    endtask

    // Advance one clock and check the DUT outputs against the model.
    task automatic tick();
        @(posedge clk);
        #2;
        if (busy) busy_cnt++;
        if (z_we) begin
            if (wr_cnt < n_exp) begin
                check("z_addr", z_addr, wr_cnt);
                check("z_data", z_data, exp_z[wr_cnt]);
            end else begin
                check("z_write_count", wr_cnt + 1, n_exp);
            end
            zcap[z_addr] = int'(z_data);
            wr_cnt++;
        end
        if (done) begin
            done_cnt++;
            check("done_busy_overlap", busy, 0);
            if (n_exp > 0) check("done_after_last_write", prev_we, 1);
        end
        prev_we = z_we;
    endtask

    task automatic clear_run(input int sx, input int sy);
        model(sx, sy);
        wr_cnt = 0;
        busy_cnt = 0;
        done_cnt = 0;
        prev_we = 1'b0;
        for (int i = 0; i < 64; i++) zcap[i] = -1;
    endtask

    task automatic run(input int sx, input int sy, input bit mid_start);
        clear_run(sx, sy);
        size_x = sx[ADDR_W:0];
        size_y = sy[ADDR_W:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        if (n_exp == 0) check("done_next_cycle", done, 1);
        for (int c = 0; c < 5000 && done_cnt == 0; c++) begin
            if (mid_start && c == 3) begin
                start = 1'b1;
                size_x = 6'd7;
                size_y = 6'd9;
            end
            if (mid_start && c == 4) start = 1'b0;
            tick();
        end
        if (done_cnt == 0) check("done_timeout", 0, 1);
        tick();
        tick();
        check("write_count", wr_cnt, n_exp);
        check("busy_cycles", busy_cnt, exp_busy);
        check("done_pulses", done_cnt, 1);
`ifdef CONV_MAC_CTRL_CYCLE_CNT_EN
        check("cycles_o", cycles, exp_busy);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_z_we"}, z_we, 0);
        check({tag, "_x_addr"}, x_addr, 0);
        check({tag, "_y_addr"}, y_addr, 0);
        check({tag, "_mul_a"}, mul_a, 0);
        check({tag, "_mul_b"}, mul_b, 0);
        check({tag, "_z_addr"}, z_addr, 0);
        check({tag, "_z_data"}, z_data, 0);
`ifdef CONV_MAC_CTRL_CYCLE_CNT_EN
        check({tag, "_cycles"}, cycles, 0);
`endif
    endtask

    task automatic load_small();
        for (int i = 0; i < 32; i++) begin
            xmem[i] = 8'd0;
            ymem[i] = 8'd0;
        end
        xmem[0] = 8'd1; xmem[1] = 8'd2; xmem[2] = 8'd3;
        ymem[0] = 8'd4; ymem[1] = 8'd5;
    endtask

    task automatic check_small(input string tag);
        check({tag, "_z0"}, zcap[0], 4);
        check({tag, "_z1"}, zcap[1], 13);
        check({tag, "_z2"}, zcap[2], 22);
        check({tag, "_z3"}, zcap[3], 15);
        check({tag, "_busy"}, busy_cnt, 20);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        size_x = '0;
        size_y = '0;
        load_small();
        clear_run(0, 0);
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        check_all_zero("reset");

        // Basic 3x2 convolution
        load_small();
        run(3, 2, 1'b0);
        check_small("t1");

        // Single-term maximum product
        xmem[0] = 8'd255;
        ymem[0] = 8'd255;
        run(1, 1, 1'b0);
        check("t2_z0", zcap[0], 65025);
        check("t2_busy", busy_cnt, 4);

        // Full-length vectors at maximum value
        for (int i = 0; i < 32; i++) begin
            xmem[i] = 8'd255;
            ymem[i] = 8'd255;
        end
        run(32, 32, 1'b0);
        check("t3_writes", wr_cnt, 63);
        check("t3_z31", zcap[31], 2080800);
        check("t3_z0", zcap[0], 65025);
        check("t3_z62", zcap[62], 65025);

        // Empty X
        run(0, 5, 1'b0);
        check("t4_busy", busy_cnt, 0);
        check("t4_writes", wr_cnt, 0);

        // Second start mid-run is ignored
        load_small();
        run(3, 2, 1'b1);
        check_small("t5");

        // Reset during MAC of output 2, then a clean rerun
        clear_run(3, 2);
        size_x = 6'd3;
        size_y = 6'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 200 && !(wr_cnt == 2 && mul_a != 8'd0); c++) tick();
        check("t6_reached_mac2", (wr_cnt == 2 && mul_a != 8'd0) ? 1 : 0, 1);
        rst = 1'b1;
        tick();
        check_all_zero("t6_rst");
        rst = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        check("t6_no_writes", wr_cnt, 2);
        check("t6_no_done", done_cnt, 0);
        run(3, 2, 1'b0);
        check_small("t6_rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
